// File: rtl/menu_pkg.sv
// Shared definitions for the menu controller: state codes, button
// indices and the board-level default timing constants.
package menu_pkg;

   typedef enum logic [1:0] {
      ST_BROWSE  = 2'd0,
      ST_CONFIRM = 2'd1,
      ST_SERVE   = 2'd2,
      ST_RSVD    = 2'd3
   } menu_state_e;

   localparam int BTN_NEXT = 0;
   localparam int BTN_PREV = 1;
   localparam int BTN_SEL  = 2;
   localparam int BTN_CLC  = 3;
   localparam int N_BTN    = 4;

   localparam logic [15:0] DEF_DB_CYC      = 16'd50000;
   localparam logic [23:0] DEF_SERVE_CYC   = 24'd8000000;
   localparam logic [27:0] DEF_TIMEOUT_CYC = 28'd160000000;

endpackage

// File: rtl/btn_cond.sv
// Push-button conditioner: 2-FF synchroniser, stability-count debounce
// and a registered one-cycle pulse on the debounced 0->1 transition.
module btn_cond
   import menu_pkg::*;
#(
   parameter logic [15:0] DB_CYC = DEF_DB_CYC
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic rise
);

   logic        sync1, sync2;
   logic        lvl, lvl_q;
   logic [15:0] cnt;

   // bring the raw pin into the clock domain
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
      end
   end

   // accept a new level only after DB_CYC consecutive disagreeing samples
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
         lvl <= 1'b0;
      end else if (sync2 == lvl) begin
         cnt <= '0;
      end else if (cnt == DB_CYC - 16'd1) begin
         lvl <= sync2;
         cnt <= '0;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

   // press pulse only; a release never produces an event
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lvl_q <= 1'b0;
         rise  <= 1'b0;
      end else begin
         lvl_q <= lvl;
         rise  <= lvl & ~lvl_q;
      end
   end

endmodule

// File: rtl/menu_fsm_param.sv
// Menu-selection controller: N_OPT-way one-hot cursor, confirm/serve
// order handshake, four conditioned buttons.
// Optional macro MENU_TIMEOUT_EN adds a CONFIRM inactivity timeout.
module menu_fsm_param
   import menu_pkg::*;
#(
   parameter int          N_OPT       = 4,
   parameter bit          WRAP        = 1'b1,
   parameter logic [15:0] DB_CYC      = DEF_DB_CYC,
   parameter logic [23:0] SERVE_CYC   = DEF_SERVE_CYC,
   parameter logic [27:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     btn_next,
   input  logic                     btn_prev,
   input  logic                     btn_sel,
   input  logic                     btn_clc,
   output logic [N_OPT-1:0]         op,
   output logic                     order_valid,
   output logic [$clog2(N_OPT)-1:0] order_idx,
   output logic                     busy,
   output logic [1:0]               state_o
);

   localparam int CW = $clog2(N_OPT);

   logic [N_BTN-1:0] pins, ev;
   menu_state_e      state;
   logic [CW-1:0]    cur, cur_inc, cur_dec;
   logic [23:0]      serve_cnt;

   function automatic logic [N_OPT-1:0] onehot(input logic [CW-1:0] c);
      onehot    = '0;
      onehot[c] = 1'b1;
   endfunction

   assign pins = {btn_clc, btn_sel, btn_prev, btn_next};

   btn_cond #(.DB_CYC(DB_CYC)) u_btn [N_BTN-1:0] (
      .clk   (clk),
      .reset (reset),
      .pin   (pins),
      .rise  (ev)
   );

   // explicit end compares so a non-power-of-2 option count wraps correctly
   assign cur_inc = (cur == CW'(N_OPT-1)) ? (WRAP ? '0 : cur) : cur + CW'(1);
   assign cur_dec = (cur == '0) ? (WRAP ? CW'(N_OPT-1) : cur) : cur - CW'(1);

   assign state_o = state;

`ifdef MENU_TIMEOUT_EN
   logic [27:0] tmo_cnt;
`else
   // the timeout length has no effect without the timeout feature
   logic unused_tmo;
   assign unused_tmo = ^TIMEOUT_CYC;
`endif

   // menu FSM; only the highest-priority edge (clc > sel > next > prev) acts
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_BROWSE;
         cur         <= '0;
         op          <= onehot('0);
         order_valid <= 1'b0;
         order_idx   <= '0;
         busy        <= 1'b0;
         serve_cnt   <= '0;
`ifdef MENU_TIMEOUT_EN
         tmo_cnt     <= '0;
`endif
      end else begin
         order_valid <= 1'b0;
         case (state)
            ST_BROWSE: begin
               if (ev[BTN_CLC]) begin
                  cur <= '0;
                  op  <= onehot('0);
               end else if (ev[BTN_SEL]) begin
                  state <= ST_CONFIRM;
`ifdef MENU_TIMEOUT_EN
                  tmo_cnt <= '0;
`endif
               end else if (ev[BTN_NEXT]) begin
                  cur <= cur_inc;
                  op  <= onehot(cur_inc);
               end else if (ev[BTN_PREV]) begin
                  cur <= cur_dec;
                  op  <= onehot(cur_dec);
               end
            end
            ST_CONFIRM: begin
               if (ev[BTN_CLC]) begin
                  state <= ST_BROWSE;
               end else if (ev[BTN_SEL]) begin
                  state       <= ST_SERVE;
                  order_valid <= 1'b1;
                  order_idx   <= cur;
                  busy        <= 1'b1;
                  serve_cnt   <= '0;
               end
`ifdef MENU_TIMEOUT_EN
               // any button activity restarts the idle count
               else if (|ev) tmo_cnt <= '0;
               else if (tmo_cnt == TIMEOUT_CYC - 28'd1) state <= ST_BROWSE;
               else tmo_cnt <= tmo_cnt + 28'd1;
`endif
            end
            ST_SERVE: begin
               if (serve_cnt == SERVE_CYC - 24'd1) begin
                  state <= ST_BROWSE;
                  cur   <= '0;
                  op    <= onehot('0);
                  busy  <= 1'b0;
               end else begin
                  serve_cnt <= serve_cnt + 24'd1;
               end
            end
            default: begin
               state <= ST_BROWSE;
               cur   <= '0;
               op    <= onehot('0);
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/menu_fsm_param.md
Name: menu_fsm_param

Overview:
Parametrised menu-selection controller for the TinyFPGA BX front panel. It is the next generation of the fixed 4-option food menu FSM.
- Takes four raw push-button pins: next, prev, select, cancel.
- Conditions each button internally: synchronise, debounce, detect the rising edge.
- Drives a one-hot highlight of N_OPT options and a two-step confirm/serve order handshake.
- Runs on the board clock with one clock domain; it does not use the divided counter clock.

Parameters:
N_OPT, 4, number of menu options; legal range 2..16.
WRAP, 1, 1 = the cursor wraps at both ends; 0 = the cursor saturates at both ends.
DB_CYC, 16'd50000, consecutive stable cycles needed to accept a new debounced button level.
SERVE_CYC, 24'd8000000, cycles spent in SERVE before returning to BROWSE.
TIMEOUT_CYC, 28'd160000000, CONFIRM inactivity timeout in cycles; used only with MENU_TIMEOUT_EN.

Ports:
clk  in  1  board clock; all flops are clocked on the rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
btn_next  in  1  raw pin, active-high; asynchronous to clk.
btn_prev  in  1  raw pin, active-high.
btn_sel  in  1  raw pin, active-high.
btn_clc  in  1  raw pin, active-high; cancel.
op  out  N_OPT  one-hot highlight of the cursor option.
order_valid  out  1  one-cycle pulse when an order is confirmed.
order_idx  out  $clog2(N_OPT)  chosen option index; valid while order_valid=1 and held through SERVE.
busy  out  1  high while in SERVE.
state_o  out  2  current state code, for LED/debug.

Behaviour:
- Reset values:
  - Synchronisers and debounced levels = 0.
  - cur = 0, state = BROWSE.
  - op = 1, order_valid = 0, order_idx = 0, busy = 0, state_o = 0.
- Button conditioning, per button:
  - 2-FF synchroniser feeds a stability counter.
  - The debounced level changes only after the synchronised input differs from it for DB_CYC consecutive cycles. Any mismatch gap clears the counter.
  - Edge pulse = debounced level 0→1; exactly one cycle wide.
  - Latency from a stable pin change to the edge pulse = DB_CYC + 3 cycles.
  - Releasing a button never generates an event.
- Priority when several edges occur in the same cycle: clc > sel > next > prev. Only the highest-priority edge acts; the rest are dropped.
- States (state_o codes): BROWSE = 0, CONFIRM = 1, SERVE = 2; code 3 is unused and recovers to BROWSE.
- BROWSE:
  - next: cur+1. At N_OPT-1 it goes to 0 if WRAP=1, else stays.
  - prev: cur-1. At 0 it goes to N_OPT-1 if WRAP=1, else stays.
  - sel: go to CONFIRM; cur is frozen.
  - clc: cur = 0; stay in BROWSE.
- CONFIRM:
  - sel: go to SERVE. order_valid=1 for one cycle on that transition; order_idx = cur, registered.
  - clc: go to BROWSE; cur is kept.
  - next/prev: ignored.
- SERVE:
  - busy = 1; all button edges are ignored, including clc.
  - A serve counter counts SERVE_CYC cycles, then the block returns to BROWSE with cur = 0 and busy = 0.
  - order_idx holds its value until the next order.
- op = 1 << cur in every state. It updates the cycle after the edge is accepted (registered).
- Reset asserted mid-operation aborts any state immediately, asynchronously, to the reset values. No order_valid is produced.
- Arithmetic: cur is $clog2(N_OPT) bits. Wrap is an explicit compare against N_OPT-1, so non-power-of-2 N_OPT works.

Optional Feature:
MENU_TIMEOUT_EN.
- Defined:
  - A timeout counter runs in CONFIRM and clears on any accepted edge or on entering CONFIRM.
  - When it reaches TIMEOUT_CYC, the FSM returns to BROWSE with cur kept and no order.
  - A sel edge in the same cycle as expiry wins: the order proceeds.
- Undefined: no counter is instantiated; CONFIRM waits indefinitely.

Decomposition:
- Package menu_pkg:
  - State encoding constants ST_BROWSE, ST_CONFIRM, ST_SERVE (2-bit).
  - Button index constants BTN_NEXT..BTN_CLC.
  - Default timing constants.
- One sub-module, btn_cond: synchroniser + debounce + rising-edge detect, parameter DB_CYC. It is instantiated four times.
- The FSM, cursor, serve counter and timeout counter live in menu_fsm_param.

Test Plan:
All scenarios use N_OPT=4, DB_CYC=4, SERVE_CYC=8, TIMEOUT_CYC=20.
1. Reset low, then release; press next three times → op 0001→0010→0100→1000. A fourth next with WRAP=1 → 0001; with WRAP=0 → stays 1000.
2. Bounce: toggle btn_next every 2 cycles for 20 cycles, then hold high for 10 → exactly one edge; op advances by one; no event on release.
3. next ×2, sel, sel → order_valid high exactly 1 cycle with order_idx=2. busy=1 for 8 cycles, then state_o=0 and op=0001.
4. In CONFIRM: press clc → back to BROWSE with op unchanged. In SERVE: press clc and next → ignored; busy stays high for the full 8 cycles.
5. Same-cycle edges on sel and next in BROWSE → CONFIRM entered, cur unchanged. Reset pulsed low during SERVE → all outputs at reset values next cycle; no order_valid.
6. MENU_TIMEOUT_EN: enter CONFIRM, idle 20 cycles → BROWSE, no order_valid. Without the macro, idle 100 cycles → still CONFIRM.
